// File: rtl/polar_butterfly_serializer_if.sv
// Frame-in / bit-out handshake bundle between the bit-reversal stage,
// the polar encoder-serializer and the modulator.
interface polar_butterfly_serializer_if #(
  parameter int N = 256
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic         data_out;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_last, busy
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, out_last, busy
  );
endinterface

// File: rtl/polar_butterfly_serializer.sv
// Polar kernel transform x = u*F^(x)LOG2N, one butterfly stage per clock,
// followed by a bit-serial valid/ready output of the codeword.

module pbs_lane #(
  parameter int LOG2N = 8
) (
  input  logic             v_i,
  input  logic [LOG2N-1:0] partner_i,
  input  logic [LOG2N-1:0] stage_i,
  output logic             v_o
);
  // partner_i[s] already holds v[i+2^s], or 0 where bit s of i is set
  always_comb begin
    v_o = v_i;
    for (int s = 0; s < LOG2N; s++)
      if (stage_i == LOG2N'(s)) v_o = v_i ^ partner_i[s];
  end
endmodule

module polar_butterfly_serializer #(
  parameter int N     = 256,
  parameter int LOG2N = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  polar_butterfly_serializer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ENC, OUT} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     v_q, v_d, v_bfly;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic [LOG2N-1:0] idx_q, idx_d;
  logic             last_beat;

  assign last_beat = (idx_q == LOG2N'(N-1));

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [LOG2N-1:0] partner;
    for (genvar s = 0; s < LOG2N; s++) begin : g_pt
      if (((i >> s) & 1) == 0) begin : g_lo
        assign partner[s] = v_q[i + (1 << s)];
      end else begin : g_hi
        assign partner[s] = 1'b0;
      end
    end
    pbs_lane #(.LOG2N(LOG2N)) u_lane (
      .v_i       (v_q[i]),
      .partner_i (partner),
      .stage_i   (stage_q),
      .v_o       (v_bfly[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      stage_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        v_d     = bus.data_in;
        stage_d = '0;
        state_d = ENC;
      end
      ENC: begin
        v_d     = v_bfly;
        stage_d = stage_q + 1'b1;
        if (stage_q == LOG2N'(LOG2N-1)) begin
          stage_d = '0;
          idx_d   = '0;
          state_d = OUT;
        end
      end
      OUT: if (bus.out_ready) begin
        // idx wraps to 0 naturally on the last beat
        idx_d = idx_q + 1'b1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only from state and idx: no path from out_ready/in_valid
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = 1'b0;
    bus.data_out  = 1'b0;
    bus.out_last  = 1'b0;
    if (state_q == OUT) begin
      bus.out_valid = 1'b1;
      bus.data_out  = v_q[idx_q];
      bus.out_last  = last_beat;
    end
  end
endmodule

// File: tb/tb_polar_butterfly_serializer.sv
// Directed bench: known codewords, random frames against a subset-XOR model,
// backpressure, back-to-back frames and mid-frame resets.
module tb_polar_butterfly_serializer;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  int   acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  polar_butterfly_serializer_if #(.N(256)) bus ();

  polar_butterfly_serializer #(.N(256), .LOG2N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // x_i = XOR of u_j over every j that contains all bits of i
  function automatic logic [255:0] model(input logic [255:0] u);
    logic [255:0] x = '0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        if ((j & i) == i) x[i] = x[i] ^ u[j];
    return x;
  endfunction

  task automatic frame(input string tag, input logic [255:0] u, input logic [255:0] exp,
                       input logic [255:0] nxt, input bit stall, input bit pulse, input bit hold);
    logic [255:0] got = '0;
    int   k, lat, guard, nlast, lastpos, errs;
    bit   pst;
    logic pbit, plast;
    errs = 0; nlast = 0; lastpos = -1; pst = 0; pbit = 1'b0; plast = 1'b0;
    bus.in_valid = 1'b1;
    bus.data_in  = u;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 1000) begin tick(); guard++; end
    chk({tag, " accept"}, guard < 1000, 1);
    tick();
    acc_cyc = cyc;
    if (hold) bus.data_in = nxt;
    else begin bus.in_valid = 1'b0; bus.data_in = ~u; end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) errs++;
      if (pulse) bus.in_valid = 1'($urandom % 2);
      tick(); lat++;
    end
    chk({tag, " latency"}, lat, 8);
    k = 0; guard = 0;
    while (k < 256 && guard < 3000) begin
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) errs++;
      if (pst && (bus.data_out !== pbit || bus.out_last !== plast)) errs++;
      if (pulse) bus.in_valid = 1'($urandom % 2);
      bus.out_ready = stall ? ($urandom % 3 != 0) : 1'b1;
      if (bus.out_ready) begin
        got[k] = bus.data_out;
        if (bus.out_last) begin nlast++; lastpos = k; end
        k++; pst = 0;
      end else begin
        pst = 1; pbit = bus.data_out; plast = bus.out_last;
      end
      tick(); guard++;
    end
    if (!hold) bus.in_valid = 1'b0;
    chk({tag, " stream"}, got, exp);
    chk({tag, " last_cnt"}, nlast, 1);
    chk({tag, " last_pos"}, lastpos, 255);
    chk({tag, " proto_err"}, errs, 0);
    chk({tag, " idle_ready"}, {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
  endtask

  initial begin
    logic [255:0] r1, r2;
    int           a0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst outs", {bus.in_ready, bus.out_valid, bus.data_out, bus.out_last, bus.busy}, 5'b10000);
    rst = 1'b0;
    tick();
    chk("post rst", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);

    frame("u_bit0",   256'h1,        256'h1,        '0, 0, 0, 0);
    frame("u_bit255", 256'h1 << 255, {256{1'b1}},   '0, 0, 0, 0);
    frame("u_ones",   {256{1'b1}},   256'h1 << 255, '0, 0, 0, 0);
    frame("u_zero",   '0,            '0,            '0, 0, 0, 0);

    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 8; w++) r1[w*32 +: 32] = $urandom;
      frame($sformatf("rand%0d", f), r1, model(r1), '0, 1, 1, 0);
    end

    for (int w = 0; w < 8; w++) begin r1[w*32 +: 32] = $urandom; r2[w*32 +: 32] = $urandom; end
    frame("b2b_a", r1, model(r1), r2, 0, 0, 1);
    a0 = acc_cyc;
    frame("b2b_b", r2, model(r2), '0, 0, 0, 0);
    chk("b2b period", acc_cyc - a0, 265);

    // reset during ENC cycle 4
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.data_in = r1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("enc pre-rst busy", bus.busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("enc rst", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    repeat (12) tick();
    chk("enc rst quiet", {bus.out_valid, bus.busy}, 2'b00);

    // reset at OUT beat 100
    bus.in_valid = 1'b1; bus.data_in = r2;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    chk("out pre-rst valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    repeat (100) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("out rst", {bus.in_ready, bus.out_valid, bus.busy, bus.out_last}, 4'b1000);
    tick();
    chk("out rst quiet", {bus.out_valid, bus.busy}, 2'b00);

    for (int w = 0; w < 8; w++) r1[w*32 +: 32] = $urandom;
    frame("after_rst", r1, model(r1), '0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/polar_butterfly_serializer.md
# polar_butterfly_serializer

Downstream stage of the 256-bit bit-reversal block in the polar encoder. Accepts one bit-reversed 256-bit vector `u` per frame and applies the polar kernel transform `x = u·F^{⊗8}` (F = [[1,0],[1,1]]) iteratively, one butterfly stage per clock. It then streams the 256-bit codeword out serially, one bit per beat, under a valid/ready handshake toward the modulator/channel interface.

## Interface
Parameters:
- `N` = 256: codeword length; power of two.
- `LOG2N` = 8: log2(N); number of butterfly stages.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  `data_in` holds a valid frame.
- `in_ready`  out  1  block can accept a frame.
- `data_in`  in  N  bit-reversed input vector; `data_in[i]` = u_i.
- `out_valid`  out  1  `data_out` holds a valid codeword bit.
- `out_ready`  in  1  consumer accepts the current bit.
- `data_out`  out  1  codeword bit x_k, k ascending from 0.
- `out_last`  out  1  high with `out_valid` on bit k = N-1.
- `busy`  out  1  high in ENC or OUT.

## Operation
- Internal `v[N-1:0]` working register, `stage` counter (LOG2N bits), `idx` counter (LOG2N bits), FSM {IDLE, ENC, OUT}.
- IDLE: `in_ready`=1. On `in_valid & in_ready`: `v <= data_in`, `stage <= 0`, go ENC.
- ENC: one stage per cycle, h = 2^stage. For every i with bit `stage` of i equal to 0: `v[i] <= v[i] ^ v[i+h]`; `v[i+h]` unchanged. All N/2 XORs are parallel within the cycle. Exactly LOG2N cycles; on `stage == LOG2N-1` go OUT with `idx <= 0`.
- Result: x_i = XOR of u_j over all j whose bit set contains i's bit set (j & i == i).
- OUT: `out_valid`=1, `data_out` = `v[idx]`, `out_last` = (`idx == N-1`). On `out_valid & out_ready`: `idx <= idx+1`. On handshake with `idx == N-1`: `idx` wraps to 0 and go IDLE. Without `out_ready`, `data_out`, `idx`, `out_last` hold stable.
- `in_ready` is 0 in ENC and OUT; `in_valid` is ignored outside IDLE (no buffering, no drop flag).
- `in_valid` in IDLE with `data_in` changing later has no effect: the vector is captured only on the accepting edge.
- Reset (any state, including mid-ENC or mid-OUT): next edge -> IDLE, `v`=0, `stage`=0, `idx`=0; the in-flight frame is discarded, no partial output continues.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `data_out`=0, `out_last`=0, `busy`=0.
- Input accepted at edge t; ENC occupies cycles t+1..t+LOG2N; first `out_valid` asserted in cycle t+LOG2N+1 (t+9 at N=256).
- With `out_ready` tied high, OUT lasts exactly N cycles; `in_ready` rises the cycle after the `out_last` handshake.
- Frame period with no backpressure: 1 + LOG2N + N = 265 cycles.
- `data_out`, `out_valid`, `out_last` are registered or decoded only from state and `idx`; no combinational path from `out_ready` or `in_valid` to any output.
- `busy` = NOT `in_ready` every cycle.

## Test plan
- Reset then u = only bit 0 set -> `out_valid` 9 cycles after accept; x_0=1, x_1..x_255=0; `out_last` only on beat 256.
- u = only bit 255 set -> all 256 output bits = 1.
- u = all ones -> x_255=1, all other bits 0; u = 0 -> 256 zero bits.
- Random u, `out_ready` toggled pseudo-randomly -> serial stream matches software model x_i = XOR{u_j : j&i==i}; `data_out` stable while stalled; `in_valid` pulses during ENC/OUT ignored (`in_ready`=0).
- Back-to-back frames with `in_valid` held high and `out_ready`=1 -> second accept in the cycle after first frame's `out_last` handshake; period 265 cycles; both codewords correct.
- `rst` asserted at cycle 4 of ENC and again at beat 100 of OUT -> next cycle `out_valid`=0, `in_ready`=1, `busy`=0; a following frame encodes correctly from beat 0.
